// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 16-bit words,
// writes them to consecutive addresses, zero-fills the rest of the memory and then releases the CPU.
module imem_loader #(
    parameter int DEPTH         = 16,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  prog_len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);
    // state  | meaning
    // IDLE   | waiting for start; start with a bad prog_len only raises err
    // GET_HI | waiting for the high byte of the current word
    // GET_LO | waiting for the low byte of the current word
    // WRITE  | single write strobe for the assembled word
    // FILL   | zero-filling the addresses after the program, one per cycle
    // DONE   | one-cycle completion pulse, CPU released
    typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, FILL, DONE} state_t;

    localparam logic [4:0] MAX_LEN   = 5'(DEPTH);
    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    state_t     state;
    logic [4:0] len;
    logic [3:0] count;
    logic [7:0] hi_byte;

    // Outputs are driven for the state being entered, so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            count      <= '0;
            hi_byte    <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (prog_len == 5'd0 || prog_len > MAX_LEN) begin
                            err <= 1'b1;
                        end else begin
                            len        <= prog_len;
                            err        <= 1'b0;
                            count      <= '0;
                            cpu_hold   <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= GET_HI;
                        end
                    end
                end
                GET_HI: begin
                    if (byte_valid) begin
                        hi_byte <= byte_in;
                        state   <= GET_LO;
                    end
                end
                GET_LO: begin
                    if (byte_valid) begin
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= count;
                        mem_wdata  <= {hi_byte, byte_in};
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if ({1'b0, count} == len - 5'd1) begin
                        if (len < MAX_LEN) begin
                            // strobe stays high straight into the zero fill
                            count     <= count + 4'd1;
                            mem_addr  <= count + 4'd1;
                            mem_wdata <= '0;
                            state     <= FILL;
                        end else begin
                            mem_we   <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= DONE;
                        end
                    end else begin
                        mem_we     <= 1'b0;
                        count      <= count + 4'd1;
                        byte_ready <= 1'b1;
                        state      <= GET_HI;
                    end
                end
                FILL: begin
                    if (count == LAST_ADDR) begin
                        mem_we   <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= DONE;
                    end else begin
                        count    <= count + 4'd1;
                        mem_addr <= count + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 16: instruction-memory words; address width is fixed at 4 bits.
REQ-002 Parameter HOLD_AT_RESET, default 0: reset value of cpu_hold.
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: asynchronous, active-high reset.
REQ-005 Port start  in  1: level-sampled request to begin a load; sampled only in IDLE.
REQ-006 Port prog_len  in  5: number of program words to load, valid range 1..16; sampled with start.
REQ-007 Port byte_in  in  8: program byte stream, high byte of each word first.
REQ-008 Port byte_valid  in  1: byte_in is valid.
REQ-009 Port byte_ready  out  1: loader accepts byte_in this cycle.
REQ-010 Port mem_we  out  1: instruction-memory write strobe.
REQ-011 Port mem_addr  out  4: instruction-memory word address.
REQ-012 Port mem_wdata  out  16: instruction-memory write data.
REQ-013 Port cpu_hold  out  1: holds PC and fetch while high.
REQ-014 Port busy  out  1: high in any state other than IDLE.
REQ-015 Port done  out  1: one-cycle pulse on successful completion.
REQ-016 Port err  out  1: sticky error flag; cleared by the next accepted start.

Function
REQ-017 States SHALL be IDLE, GET_HI, GET_LO, WRITE, FILL, DONE.
REQ-018 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high.
REQ-019 byte_ready SHALL be high only in GET_HI and GET_LO, with no combinational dependence on byte_valid.
REQ-020 IDLE with start=1 and prog_len in 1..16: latch prog_len, clear err, clear word counter, set cpu_hold=1, go to GET_HI.
REQ-021 IDLE with start=1 and prog_len=0 or prog_len>16: set err=1, stay in IDLE, leave cpu_hold unchanged.
REQ-022 GET_HI: on transfer, latch byte_in into data[15:8] and go to GET_LO; otherwise hold.
REQ-023 GET_LO: on transfer, latch byte_in into data[7:0] and go to WRITE; otherwise hold.
REQ-024 WRITE (exactly one cycle): mem_we=1, mem_addr=counter, mem_wdata={hi,lo}.
REQ-025 WRITE exit: if counter=len-1 and len<16, then counter+1 and go to FILL; if counter=len-1 and len=16, go to DONE; otherwise counter+1 and go to GET_HI.
REQ-026 FILL: mem_we=1, mem_wdata=0, mem_addr=counter, one address per cycle.
REQ-027 FILL exit: after writing address 15, go to DONE; the counter SHALL never wrap past 15.
REQ-028 DONE (one cycle): done=1, cpu_hold=0, then go to IDLE.
REQ-029 Outside WRITE and FILL: mem_we=0, with mem_addr and mem_wdata held at their last values.
REQ-030 abort behaviour: a start pulse while busy SHALL be ignored.
REQ-031 Minimum load latency: 3*len + (16-len) + 1 cycles from start acceptance to done, assuming byte_valid held high.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst SHALL immediately force: state=IDLE, counter=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_ready=0, busy=0, done=0, err=0, cpu_hold=HOLD_AT_RESET.
REQ-034 rst asserted mid-load SHALL abandon the load with no further write strobes; memory contents are then undefined and software must reload.

Verification
REQ-035 Scenario: prog_len=7; bytes 0x20,0x84,0x21,0x06,0x8D,0x81,0x84,0x81,0x71,0x01,0xA0,0x02,0xE0,0x00 streamed continuously -> writes to addr 0..6 = 0x2084,0x2106,0x8D81,0x8481,0x7101,0xA002,0xE000; zeros to addr 7..15; done after 31 cycles; cpu_hold low afterwards.
REQ-036 Scenario: prog_len=16, byte_valid toggled every other cycle -> no byte lost or duplicated; 16 writes; no FILL cycles; done pulse asserted.
REQ-037 Scenario: start with prog_len=0, then prog_len=17 -> err=1, busy=0, no mem_we; a subsequent valid start clears err.
REQ-038 Scenario: start pulsed again during GET_LO -> ignored; latched prog_len and write sequence unchanged.
REQ-039 Scenario: rst asserted in FILL at addr 9 -> mem_we=0 in the same cycle; state IDLE; cpu_hold=HOLD_AT_RESET.
REQ-040 Scenario: byte_valid=0 for 50 cycles in GET_HI -> state held, byte_ready=1, mem_we=0, cpu_hold=1.
